// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: state encoding shared by the loop sequencer files.
package loop_seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/loop_idx_counter.sv
// loop_idx_counter: index counter with latched limit; wraps to 0 after the limit.
module loop_idx_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] q,
    output logic             at_max
);
    logic [WIDTH-1:0] lim_q;

    assign at_max = q == lim_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            lim_q <= '0;
        end else if (load) begin
            q     <= '0;
            lim_q <= lim;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_max ? '0 : q + WIDTH'(1);
        end
    end
endmodule

// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: two-level loop sequencer (inner/outer) with start/done handshake.
// Optional stall-cycle counter enabled by defining LOOP_SEQ_STALL_CNT_EN.
module loop_seq_ctrl
    import loop_seq_pkg::*;
#(
    parameter int IW = 4,
    parameter int OW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [IW-1:0] inner_max,
    input  logic [OW-1:0] outer_max,
    input  logic          stall,
    output logic          busy,
    output logic          step,
    output logic [IW-1:0] inner_idx,
    output logic [OW-1:0] outer_idx,
    output logic          inner_last,
    output logic          outer_last,
    output logic          done,
    output logic [CW-1:0] stall_cnt
);
    state_t state;
    logic   accept, inner_at_max, outer_at_max;

    assign busy       = state == S_RUN;
    assign done       = state == S_DONE;
    assign accept     = state == S_IDLE && start && !abort;
    assign step       = busy && !stall && !abort;
    assign inner_last = step && inner_at_max;
    assign outer_last = inner_last && outer_at_max;

    // Both counters wrap to 0 on the final step, so indices are 0 outside RUN.
    loop_idx_counter #(.WIDTH(IW)) u_inner (
        .clk(clk), .rst(rst), .clr(busy && abort), .load(accept), .en(step),
        .lim(inner_max), .q(inner_idx), .at_max(inner_at_max)
    );

    loop_idx_counter #(.WIDTH(OW)) u_outer (
        .clk(clk), .rst(rst), .clr(busy && abort), .load(accept), .en(inner_last),
        .lim(outer_max), .q(outer_idx), .at_max(outer_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  state <= accept ? S_RUN : S_IDLE;
                S_RUN:   state <= abort ? S_IDLE : (outer_last ? S_DONE : S_RUN);
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOOP_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept)
            stall_cnt <= '0;
        else if (busy && stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CW'(1);
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_loop_seq_ctrl.sv
// tb_loop_seq_ctrl: directed plus random stimulus against a step-count reference model.
module tb_loop_seq_ctrl;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, stall;
    logic [IW-1:0] inner_max;
    logic [OW-1:0] outer_max;
    logic          busy, step, inner_last, outer_last, done;
    logic [IW-1:0] inner_idx;
    logic [OW-1:0] outer_idx;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    // model: mode 0 idle, 1 run, 2 done; k = steps issued in this sequence
    int m_mode = 0, m_k = 0, m_im = 0, m_om = 0, m_sc = 0;

    loop_seq_ctrl #(.IW(IW), .OW(OW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .inner_max(inner_max), .outer_max(outer_max), .stall(stall),
        .busy(busy), .step(step), .inner_idx(inner_idx), .outer_idx(outer_idx),
        .inner_last(inner_last), .outer_last(outer_last), .done(done),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        int  ii, oo, sc_exp;
        bit  b, s;
        @(negedge clk);
        b  = m_mode == 1;
        s  = b && !stall && !abort;
        ii = b ? m_k % (m_im + 1) : 0;
        oo = b ? m_k / (m_im + 1) : 0;
`ifdef LOOP_SEQ_STALL_CNT_EN
        sc_exp = m_sc;
`else
        sc_exp = 0;
`endif
        check("busy", 32'(busy), 32'(b));
        check("step", 32'(step), 32'(s));
        check("inner_idx", 32'(inner_idx), ii);
        check("outer_idx", 32'(outer_idx), oo);
        check("inner_last", 32'(inner_last), 32'(s && ii == m_im));
        check("outer_last", 32'(outer_last), 32'(s && ii == m_im && oo == m_om));
        check("done", 32'(done), 32'(m_mode == 2));
        check("stall_cnt", 32'(stall_cnt), sc_exp);
        if (rst) begin
            m_mode = 0; m_k = 0; m_sc = 0; m_im = 0; m_om = 0;
        end else if (m_mode == 0) begin
            if (start && !abort) begin
                m_mode = 1; m_k = 0; m_sc = 0;
                m_im = int'(inner_max); m_om = int'(outer_max);
            end
        end else if (m_mode == 1) begin
            if (stall && m_sc < (1 << CW) - 1) m_sc++;
            if (abort) begin
                m_mode = 0; m_k = 0;
            end else if (!stall) begin
                m_k++;
                if (m_k == (m_im + 1) * (m_om + 1)) begin
                    m_mode = 2; m_k = 0;
                end
            end
        end else begin
            m_mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit st, input bit ab, input bit sl,
                         input int im, input int om);
        rst = r; start = st; abort = ab; stall = sl;
        inner_max = IW'(im); outer_max = OW'(om);
        cycle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        inner_max = '0; outer_max = '0;
        @(posedge clk);
        #1;
        repeat (2) drive(1, 0, 0, 0, 0, 0);
        // 3x2 loop; maxima inputs change after accept and must be ignored
        drive(0, 1, 0, 0, 2, 1);
        repeat (8) drive(0, 0, 0, 0, 0, 0);
        // single-iteration loop
        drive(0, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 5, 5);
        // stall three cycles at step 2
        drive(0, 1, 0, 0, 3, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        // abort on the final step, then restart
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 2, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        // reset at (1,1), then a fresh sequence
        drive(0, 1, 0, 0, 1, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 1);
        repeat (6) drive(0, 0, 0, 0, 0, 0);
        // start held high across DONE
        repeat (12) drive(0, 1, 0, 0, 1, 0);
        // stall counter saturation, then abort
        drive(0, 1, 0, 0, 15, 15);
        repeat (20) drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        // random traffic
        repeat (3000)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
